// File: rtl/kbd_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scan controller.
package kbd_pkg;

  localparam int unsigned KEY_NUM = 16;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned EVT_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StCompare,
    StEmit
  } kbd_state_e;

  typedef struct packed {
    logic              press;
    logic [CODE_W-1:0] code;
  } kbd_evt_t;

  function automatic logic [CODE_W-1:0] lowest_key(input logic [KEY_NUM-1:0] keys);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (keys[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic single_key(input logic [KEY_NUM-1:0] keys);
    return (keys != '0) && ((keys & (keys - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// First-word fall-through synchronous FIFO for key events; a push while full
// is accepted only when a pop frees a slot in the same cycle.
module kbd_evt_fifo #(
  parameter int unsigned Width = 5,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AddrW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AddrW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: data_o is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, snapshot debounce, press/release events.
// Define KBD_REPEAT_EN to add auto-repeat for a single held key.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 1000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned REPEAT_SCANS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         scan_en,
  input  logic [3:0]   col,
  output logic [3:0]   row,
  output logic         evt_valid,
  output logic [4:0]   evt_data,
  input  logic         evt_ready,
  output logic         irq,
  input  logic         ovf_clear,
  output logic         ovf,
  output logic [15:0]  key_state
);

  localparam int unsigned DwellW = $clog2(ROW_DWELL);
  localparam int unsigned StabW  = $clog2(DEBOUNCE + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(ROW_DWELL - 1);
  localparam logic [StabW-1:0]  StabMax   = StabW'(DEBOUNCE - 1);

  kbd_state_e          state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [KEY_NUM-1:0]  raw_q, raw_d;
  logic [KEY_NUM-1:0]  prev_q, prev_d;
  logic [KEY_NUM-1:0]  keys_q, keys_d;
  logic [StabW-1:0]    stab_q, stab_d, stab_nxt;
  logic                ovf_q, ovf_d;

  logic [KEY_NUM-1:0]  diff;
  logic [CODE_W-1:0]   emit_idx;
  logic                emit_last;
  logic                push;
  kbd_evt_t            push_evt;
  logic                fifo_full, fifo_empty;
  logic [EVT_W-1:0]    fifo_dout;
  logic                overflow;

`ifdef KBD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  assign diff      = raw_q ^ keys_q;
  assign emit_idx  = lowest_key(diff);
  assign emit_last = ((diff & (diff - 16'd1)) == '0);
  // Count of extra identical snapshots, saturating once debounce is satisfied.
  assign stab_nxt  = (raw_q != prev_q) ? '0 :
                     (stab_q >= StabMax) ? stab_q : stab_q + StabW'(1);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dwell_d  = dwell_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    keys_d   = keys_q;
    stab_d   = stab_q;
    push     = 1'b0;
    push_evt = '0;
`ifdef KBD_REPEAT_EN
    rep_d    = rep_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (scan_en) begin
          state_d = StDrive;
          row_d   = '0;
          dwell_d = '0;
        end
      end
      StDrive: begin
        if (dwell_q == DwellLast) begin
          raw_d[{row_q, 2'b00} +: 4] = ~col;
          dwell_d = '0;
          if (!scan_en) begin
            state_d = StIdle;
          end else if (row_q == 2'd3) begin
            state_d = StCompare;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end
      StCompare: begin
        stab_d = stab_nxt;
        prev_d = raw_q;
        if ((32'(stab_nxt) + 32'd1 >= DEBOUNCE) && (raw_q != keys_q)) begin
          state_d = StEmit;
        end else begin
          state_d = scan_en ? StDrive : StIdle;
          row_d   = '0;
          dwell_d = '0;
        end
`ifdef KBD_REPEAT_EN
        if (single_key(keys_q)) begin
          if (32'(rep_q) + 32'd1 >= REPEAT_SCANS) begin
            push     = 1'b1;
            push_evt = '{press: 1'b1, code: lowest_key(keys_q)};
            rep_d    = '0;
          end else begin
            rep_d = rep_q + RepW'(1);
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      StEmit: begin
        push             = 1'b1;
        push_evt         = '{press: raw_q[emit_idx], code: emit_idx};
        keys_d[emit_idx] = raw_q[emit_idx];
`ifdef KBD_REPEAT_EN
        rep_d            = '0;
`endif
        if (emit_last) begin
          state_d = scan_en ? StDrive : StIdle;
          row_d   = '0;
          dwell_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO with no pop this cycle drops the event; clear wins over a new drop.
  assign overflow = push & fifo_full & ~evt_ready;
  assign ovf_d    = ovf_clear ? 1'b0 : (ovf_q | overflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      dwell_q <= '0;
      raw_q   <= '0;
      prev_q  <= '0;
      keys_q  <= '0;
      stab_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      keys_q  <= keys_d;
      stab_q  <= stab_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef KBD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`endif

  kbd_evt_fifo #(
    .Width (EVT_W),
    .Depth (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_evt),
    .full_o  (fifo_full),
    .pop_i   (evt_ready),
    .data_o  (fifo_dout),
    .empty_o (fifo_empty)
  );

  assign row       = (state_q == StDrive) ? ~(4'b0001 << row_q) : 4'hF;
  assign evt_valid = ~fifo_empty;
  assign evt_data  = fifo_dout;
  assign irq       = ~fifo_empty | ovf_q;
  assign ovf       = ovf_q;
  assign key_state = keys_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: a scan-position/queue model checked
// every cycle, plus directed scenarios with literal expected values.
module tb_kbd_scan_ctrl;

  localparam int RD = 4;
  localparam int DB = 4;
  localparam int DEP = 2;
  localparam int IdlePh = -1;
  localparam int CmpPh = 4 * RD;
  localparam int EmitPh = 4 * RD + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic        evt_ready = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        evt_valid, irq, ovf;
  logic [4:0]  evt_data;
  logic [15:0] key_state;
  logic [15:0] pressed = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: scan position, snapshots, pending emit list, FIFO contents.
  int          m_phase;
  logic [15:0] m_raw, m_prev, m_keys;
  int          m_same;
  int          m_emit[$];
  logic [4:0]  m_fifo[$];
  logic        m_ovf;

  kbd_scan_ctrl #(
    .ROW_DWELL    (RD),
    .DEBOUNCE     (DB),
    .FIFO_DEPTH   (DEP),
    .REPEAT_SCANS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .col       (col),
    .row       (row),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .irq       (irq),
    .ovf_clear (ovf_clear),
    .ovf       (ovf),
    .key_state (key_state)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row[r]) col = col & ~pressed[4*r +: 4];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = IdlePh;
    m_raw = '0;
    m_prev = '0;
    m_keys = '0;
    m_same = 1;
    m_emit.delete();
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit         pop_ok;
    bit         have_push;
    logic [4:0] pe;
    int         r, n;
    pop_ok = evt_ready && (m_fifo.size() > 0);
    have_push = 1'b0;
    pe = '0;
    if (m_phase == IdlePh) begin
      if (scan_en) m_phase = 0;
    end else if (m_phase < CmpPh) begin
      r = m_phase / RD;
      if (m_phase % RD == RD - 1) begin
        for (int c = 0; c < 4; c++) m_raw[r*4+c] = pressed[r*4+c];
        m_phase = scan_en ? m_phase + 1 : IdlePh;
      end else begin
        m_phase++;
      end
    end else if (m_phase == CmpPh) begin
      m_same = (m_raw == m_prev) ? m_same + 1 : 1;
      m_prev = m_raw;
      if (m_same >= DB && m_raw != m_keys) begin
        for (int k = 0; k < 16; k++) if (m_raw[k] != m_keys[k]) m_emit.push_back(k);
        m_phase = EmitPh;
      end else begin
        m_phase = scan_en ? 0 : IdlePh;
      end
    end else begin
      n = m_emit.pop_front();
      have_push = 1'b1;
      pe = {m_raw[n], 4'(n)};
      m_keys[n] = m_raw[n];
      if (m_emit.size() == 0) m_phase = scan_en ? 0 : IdlePh;
    end
    if (pop_ok) void'(m_fifo.pop_front());
    if (have_push) begin
      if (m_fifo.size() < DEP) m_fifo.push_back(pe);
      else m_ovf = 1'b1;
    end
    if (ovf_clear) m_ovf = 1'b0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [3:0] er;
    logic [4:0] ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        er = (m_phase >= 0 && m_phase < CmpPh) ? ~(4'b0001 << (m_phase / RD)) : 4'hF;
        ed = (m_fifo.size() > 0) ? m_fifo[0] : 5'd0;
        check("m_row", 32'(row), 32'(er));
        check("m_evt_valid", 32'(evt_valid), 32'(m_fifo.size() > 0));
        check("m_evt_data", 32'(evt_data), 32'(ed));
        check("m_irq", 32'(irq), 32'((m_fifo.size() > 0) || m_ovf));
        check("m_ovf", 32'(ovf), 32'(m_ovf));
        check("m_key_state", 32'(key_state), 32'(m_keys));
      end
    end
  end

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!evt_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!evt_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: evt_valid=0 after %0d cycles, required 1", name, k);
    end
  endtask

  task automatic wait_phase(input int ph, input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (m_phase != ph && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (m_phase != ph) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: phase %0d not reached, required %0d", name, m_phase, ph);
    end
  endtask

  task automatic wait_row_active(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (row == 4'hF && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (row == 4'hF) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: row stayed 0xF, required a driven row", name);
    end
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [4];
    seq = '{4'hE, 4'hD, 4'hB, 4'h7};

    #12;
    check("rst_row", 32'(row), 32'hF);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_data", 32'(evt_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_key_state", 32'(key_state), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    scan_en = 1'b1;

    // Idle keypad: row walk E,D,B,7 with RD cycles each.
    wait_row_active("row_start");
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < RD; k++) begin
        check("row_seq", 32'(row), 32'(seq[r]));
        @(negedge clk);
      end
    end
    repeat (5 * (CmpPh + 1)) @(negedge clk);
    check("idle_key_state", 32'(key_state), 32'h0);
    check("idle_evt_valid", 32'(evt_valid), 32'h0);

    // Key 6 held, then released.
    pressed = 16'h0040;
    wait_valid("key6_press_wait");
    check("key6_press_data", 32'(evt_data), 32'h16);
    check("key6_key_state", 32'(key_state), 32'h0040);
    check("key6_irq", 32'(irq), 32'h1);
    pop();
    @(negedge clk);
    check("key6_irq_after_pop", 32'(irq), 32'h0);
    repeat (3 * (CmpPh + 1)) @(negedge clk);
    check("key6_single_event", 32'(evt_valid), 32'h0);
    pressed = 16'h0000;
    wait_valid("key6_release_wait");
    check("key6_release_data", 32'(evt_data), 32'h06);
    check("key6_release_state", 32'(key_state), 32'h0);
    pop();

    // Key 9 bounces on/off/on across scans, then stays pressed.
    wait_phase(CmpPh, "bounce_sync0");
    pressed = 16'h0200;
    wait_phase(CmpPh, "bounce_sync1");
    pressed = 16'h0000;
    wait_phase(CmpPh, "bounce_sync2");
    pressed = 16'h0200;
    repeat (3) wait_phase(CmpPh, "bounce_settle");
    check("bounce_no_early_event", 32'(evt_valid), 32'h0);
    wait_valid("key9_press_wait");
    check("key9_press_data", 32'(evt_data), 32'h19);
    pop();
    @(negedge clk);
    check("key9_only_one", 32'(evt_valid), 32'h0);
    pressed = 16'h0000;
    wait_valid("key9_release_wait");
    check("key9_release_data", 32'(evt_data), 32'h09);
    pop();

    // Keys 0 and 15 in the same scan: two consecutive events.
    pressed = 16'h8001;
    wait_valid("k0_15_wait");
    check("k0_press_data", 32'(evt_data), 32'h10);
    pop();
    @(negedge clk);
    check("k15_valid", 32'(evt_valid), 32'h1);
    check("k15_press_data", 32'(evt_data), 32'h1F);
    pop();
    pressed = 16'h0000;
    wait_valid("k0_15_release_wait");
    check("k0_release_data", 32'(evt_data), 32'h00);
    pop();
    @(negedge clk);
    check("k15_release_data", 32'(evt_data), 32'h0F);
    pop();

    // Three presses into a 2-deep FIFO with no pops: one dropped.
    pressed = 16'h000E;
    wait_valid("ovf_wait");
    repeat (3) @(negedge clk);
    check("ovf_set", 32'(ovf), 32'h1);
    check("ovf_irq", 32'(irq), 32'h1);
    check("ovf_key_state", 32'(key_state), 32'h000E);
    check("ovf_head", 32'(evt_data), 32'h11);
    ovf_clear = 1'b1;
    @(posedge clk);
    #1 ovf_clear = 1'b0;
    @(negedge clk);
    check("ovf_cleared", 32'(ovf), 32'h0);
    check("ovf_irq_held", 32'(irq), 32'h1);
    pop();
    @(negedge clk);
    check("ovf_second", 32'(evt_data), 32'h12);
    check("ovf_irq_one_left", 32'(irq), 32'h1);
    pop();
    @(negedge clk);
    check("ovf_drained_irq", 32'(irq), 32'h0);
    check("ovf_drained_valid", 32'(evt_valid), 32'h0);

    // Asynchronous reset in the middle of an emit burst.
    pressed = 16'h0030;
    wait_phase(EmitPh, "emit_wait");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_row", 32'(row), 32'hF);
    check("arst_evt_valid", 32'(evt_valid), 32'h0);
    check("arst_key_state", 32'(key_state), 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_row_active("restart");
    check("restart_row0", 32'(row), 32'hE);
    repeat (6 * (CmpPh + 1)) @(negedge clk);

    scan_en = 1'b0;
    repeat (40) @(negedge clk);
    check("scan_off_row", 32'(row), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
Scan sequencer and event scheduler for the 4x4 matrix keypad. It drives the row strobes and times the per-row dwell. It samples the columns, debounces complete 16-key snapshots, and converts press/release edges into coded events. Events are buffered in a small FIFO for the CPU-side APB/AHB key peripheral, and a level interrupt is raised while events are pending.

Parameters:
ROW_DWELL, 1000, clk cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE, 4, consecutive identical full-matrix snapshots required before a change is accepted (>=1)
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
REPEAT_SCANS, 64, scans between auto-repeat events (used only with KBD_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
scan_en  in  1  1 = scanning runs; 0 = finish current row, then idle with rows released
col  in  4  column inputs, active-low (pressed = 0), externally synchronised
row  out  4  row drive, active-low one-hot; 4'hF when idle
evt_valid  out  1  FIFO not empty
evt_data  out  5  {press(1)/release(0), key_code[3:0]}, key_code = row*4 + col_index
evt_ready  in  1  pop handshake; pop occurs when evt_valid & evt_ready
irq  out  1  level interrupt: evt_valid | ovf
ovf_clear  in  1  clears sticky overflow flag
ovf  out  1  sticky: an event was dropped because the FIFO was full
key_state  out  16  debounced pressed map, bit n = key_code n

Behaviour:
- Reset (async, rst=1): row=4'hF, FIFO empty, evt_valid=0, evt_data=0, irq=0, ovf=0, key_state=0. Internal state: stable count=0, snapshot regs=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: row=F. Moves to DRIVE when scan_en=1. Row index restarts at 0.
  - DRIVE: row[r]=0. Dwell counter runs 0..ROW_DWELL-1. On the last count, ~col is latched into raw[4r+3:4r].
  - r<3: r increments and the FSM stays in DRIVE for the next row.
  - r=3: FSM moves to COMPARE.
  - If scan_en=0 when a row completes, the FSM goes to IDLE. The partial snapshot is discarded and the stable count is kept.
  - COMPARE (1 cycle): if raw==prev_raw, stable_cnt saturates upward; otherwise stable_cnt=0. prev_raw<=raw.
  - Leaving COMPARE: if stable_cnt+1 >= DEBOUNCE and raw != key_state, the FSM goes to EMIT; otherwise it goes to DRIVE (r=0).
  - EMIT: one cycle per differing bit, lowest key_code first. Each cycle pushes {raw[n], n} and updates key_state[n]. When no differing bits remain, the FSM goes to DRIVE (r=0).
- Full-matrix scan latency: 4*ROW_DWELL + 1 cycles, plus one cycle per emitted event.
- FIFO behaviour:
  - First-word fall-through: evt_data is valid combinationally with evt_valid.
  - Push and pop in the same cycle while full: both succeed, nothing is dropped.
  - Push while full without a pop: the event is dropped, ovf is set, and key_state still updates.
  - Pop while empty: ignored.
- ovf_clear has priority over a same-cycle overflow set: clear wins.
- Multiple simultaneous keys are all reported; ghosting is not masked.
- scan_en deasserted during EMIT: the EMIT sequence completes before the FSM goes to IDLE.

Optional Feature:
Macro KBD_REPEAT_EN.
- Defined:
  - When exactly one key is pressed in key_state, a repeat counter counts completed scans.
  - Each time it reaches REPEAT_SCANS, a {1, code} press event is pushed during COMPARE, subject to the same overflow rule, and the counter restarts.
  - Any change in key_state, or not exactly one key pressed, resets the counter.
- Not defined: no repeat logic or counter is generated, and the REPEAT_SCANS parameter is unused.

Decomposition:
- Package kbd_pkg holds:
  - FSM state enum (IDLE, DRIVE, COMPARE, EMIT)
  - KEY_NUM=16, CODE_W=4, EVT_W=5
  - event struct {press, code}
- Sub-module kbd_evt_fifo: parameterised FWFT synchronous FIFO (push/full/pop/empty). Same clk and rst.

Test Plan:
- Reset, then scan_en=1, no keys, ROW_DWELL=4: row cycles E,D,B,7 each for 4 clks; evt_valid stays 0, key_state=0.
- Key 6 (row1,col2) held, DEBOUNCE=4: exactly one event 5'b1_0110 after the 4th identical scan; key_state=16'h0040, irq=1. Pop clears irq. After release, event 5'b0_0110 arrives.
- Key 9 bounces (toggles every scan for 3 scans, then stable): no event until 4 stable scans; only one press event total.
- Keys 0 and 15 pressed in the same scan: events 1_0000 then 1_1111 on consecutive EMIT cycles.
- FIFO_DEPTH=2 with evt_ready=0 and 3 presses: 2 events kept, ovf=1, irq=1. ovf_clear clears ovf; irq stays 1 until both events are popped.
- rst asserted mid-EMIT: row=F and FIFO empty in the same cycle with no clock edge, key_state=0. Scanning restarts from row 0 after rst=0.
